// File: rtl/bias_sram_pkg.sv
// Shared types and sizes for the bias SRAM controller.
// Optional feature macro: BIAS_SRAM_RR_EN (round-robin arbitration on conflict).
package bias_sram_pkg;

   localparam int unsigned DEPTH      = 384;
   localparam int unsigned AW         = $clog2(DEPTH);
   localparam int unsigned DW         = 32;
   localparam int unsigned RESP_DEPTH = 2;
   localparam int unsigned CNT_W      = $clog2(RESP_DEPTH + 1);
   localparam int unsigned PTR_W      = $clog2(RESP_DEPTH);

   typedef logic [AW-1:0] bias_addr_t;
   typedef logic [DW-1:0] bias_word_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WR,
      GNT_RD
   } bias_gnt_e;

   // True when an address lies outside the physical SRAM.
   function automatic logic addr_oor(input bias_addr_t addr);
      return addr >= bias_addr_t'(DEPTH);
   endfunction

endpackage

// File: rtl/bias_resp_fifo.sv
// RESP_DEPTH x DW synchronous response FIFO. Head is read straight from
// registered storage, so there is no combinational path from push data to head.
module bias_resp_fifo
   import bias_sram_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [DW-1:0]    push_data_i,
   input  logic             pop_i,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o,
   output logic [DW-1:0]    head_o
);

   bias_word_t       mem_q [RESP_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   // Pointers wrap naturally because RESP_DEPTH is a power of two.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage write.
   // NOTE: data storage has no reset; validity is tracked by count_q, which is reset.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

`ifndef SYNTHESIS
   // The upstream credit scheme must never push into a full FIFO without a pop.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !pop_i && (count_q == CNT_W'(RESP_DEPTH))));
`endif

endmodule

// File: rtl/bias_sram_ctrl.sv
// Bias SRAM controller: arbitrates a DMA load channel and a PE fetch channel
// onto the single SRAM port and hides the 1-cycle read latency behind a
// small response FIFO.
// Optional feature macro: BIAS_SRAM_RR_EN -- round-robin on conflict when
// defined, otherwise writes always win.
module bias_sram_ctrl
   import bias_sram_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [AW-1:0] rd_addr,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_data,
   output logic          oor_err,
   output logic          sram_cs,
   output logic          sram_oe,
   output logic          sram_web,
   output logic [AW-1:0] sram_a,
   output logic [DW-1:0] sram_di,
   input  logic [DW-1:0] sram_do
);

   bias_gnt_e        gnt;
   logic             wr_oor, rd_oor;
   logic             rd_ok, resp_pop, fifo_empty, fifo_push;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   credit_used;
   bias_word_t       fifo_push_data;

   logic rd_inflight_q, rd_oor_q, sram_oe_q, oor_err_q;
`ifdef BIAS_SRAM_RR_EN
   logic rr_wr_q;   // 1: write wins the next conflict
`endif

   assign wr_oor   = addr_oor(wr_addr);
   assign rd_oor   = addr_oor(rd_addr);
   assign resp_pop = resp_valid & resp_ready;

   // A slot being popped this cycle is free by the time the new read lands,
   // which is what lets back-to-back reads run at one per cycle.
   assign credit_used = {1'b0, fifo_count}
                      + {{CNT_W{1'b0}}, rd_inflight_q}
                      - {{CNT_W{1'b0}}, resp_pop};
   assign rd_ok = credit_used < (CNT_W+1)'(RESP_DEPTH);

   // Per-cycle grant selection between the eligible channels.
   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      gnt = GNT_NONE;
      if (rst_n) begin
         if (wr_valid && rd_valid && rd_ok) begin
`ifdef BIAS_SRAM_RR_EN
            gnt = rr_wr_q ? GNT_WR : GNT_RD;
`else
            gnt = GNT_WR;
`endif
         end else if (wr_valid) begin
            gnt = GNT_WR;
         end else if (rd_valid && rd_ok) begin
            gnt = GNT_RD;
         end
      end
   end

   assign wr_ready = (gnt == GNT_WR);
   assign rd_ready = (gnt == GNT_RD);

   // Out-of-range requests complete their handshake but never touch the SRAM.
   assign sram_cs  = (wr_ready & ~wr_oor) | (rd_ready & ~rd_oor);
   assign sram_web = ~wr_ready;
   assign sram_a   = wr_ready ? wr_addr : (rd_ready ? rd_addr : '0);
   assign sram_di  = rst_n ? wr_data : '0;
   assign sram_oe  = sram_oe_q;
   assign oor_err  = oor_err_q;

   // Read pipeline tracking and the sticky out-of-range flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_inflight_q <= 1'b0;
         rd_oor_q      <= 1'b0;
         sram_oe_q     <= 1'b0;
         oor_err_q     <= 1'b0;
      end else begin
         rd_inflight_q <= rd_ready;
         rd_oor_q      <= rd_ready & rd_oor;
         sram_oe_q     <= rd_ready;
         if ((wr_ready & wr_oor) | (rd_ready & rd_oor)) oor_err_q <= 1'b1;
      end
   end

`ifdef BIAS_SRAM_RR_EN
   // Round-robin pointer moves only on a conflict; the winner drops to lowest priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_wr_q <= 1'b1;
      end else if (wr_valid && rd_valid && rd_ok) begin
         rr_wr_q <= (gnt == GNT_RD);
      end
   end
`endif

   // SRAM data is captured one edge after the read was issued.
   assign fifo_push      = rd_inflight_q;
   assign fifo_push_data = rd_oor_q ? '0 : sram_do;

   bias_resp_fifo u_resp_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (fifo_push),
      .push_data_i (fifo_push_data),
      .pop_i       (resp_pop),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .head_o      (resp_data)
   );

   assign resp_valid = ~fifo_empty;

endmodule

// File: tb/tb_bias_sram_ctrl.sv
// Self-checking bench for bias_sram_ctrl with a behavioural 384x32 SRAM.
// Build with BIAS_SRAM_RR_EN defined to check round-robin arbitration.

// Behavioural single-port SRAM: synchronous write, 1-cycle read latency.
module SRAM_32b_384w_2k (
   input  logic        CK,
   input  logic        CS,
   input  logic        OE,
   input  logic        WEB,
   input  logic [8:0]  A,
   input  logic [31:0] DI,
   output logic [31:0] DO
);
   logic [31:0] mem [384];
   logic [31:0] dout = '0;

   always @(posedge CK) begin
      if (CS && (int'(A) < 384)) begin
         if (!WEB) mem[A] <= DI;
         else      dout   <= mem[A];
      end
   end

   assign DO = OE ? dout : '0;
endmodule

module tb_bias_sram_ctrl;
   import bias_sram_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_valid, rd_valid, resp_ready;
   logic          wr_ready, rd_ready, resp_valid, oor_err;
   logic [AW-1:0] wr_addr, rd_addr, sram_a;
   logic [DW-1:0] wr_data, resp_data, sram_di, sram_do;
   logic          sram_cs, sram_oe, sram_web;

   int n_cmp = 0;
   int n_bad = 0;

   // Streaming bookkeeping shared by the stream tests.
   int          acc;
   logic [31:0] got[$];
   int          got_cyc[$];

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] exp;
      string       name;
   } rd_vec_t;
   rd_vec_t tbl[6];

   always #5 clk = ~clk;

   bias_sram_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_addr    (rd_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .oor_err    (oor_err),
      .sram_cs    (sram_cs),
      .sram_oe    (sram_oe),
      .sram_web   (sram_web),
      .sram_a     (sram_a),
      .sram_di    (sram_di),
      .sram_do    (sram_do)
   );

   SRAM_32b_384w_2k u_sram (
      .CK  (clk),
      .CS  (sram_cs),
      .OE  (sram_oe),
      .WEB (sram_web),
      .A   (sram_a),
      .DI  (sram_di),
      .DO  (sram_do)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single read with latency check: accept, nothing the next cycle, data the one after.
   task automatic do_read(input logic [8:0] addr, input logic [31:0] exp, input string name);
      int waited = 0;
      resp_ready = 1'b1;
      rd_valid   = 1'b1;
      rd_addr    = addr;
      @(negedge clk);
      while (!rd_ready && waited < 10) begin
         tick();
         @(negedge clk);
         waited++;
      end
      check({name, "_acc"}, 32'(rd_ready), 32'd1);
      tick();
      rd_valid = 1'b0;
      @(negedge clk);
      check({name, "_early"}, 32'(resp_valid), 32'd0);
      tick();
      @(negedge clk);
      check({name, "_valid"}, 32'(resp_valid), 32'd1);
      check({name, "_data"}, resp_data, exp);
      tick();
   endtask

   // One cycle of a streaming read sequence from base..base+n-1.
   task automatic stream_cycle(input int base, input int n, input int cyc);
      rd_valid = (acc < n);
      rd_addr  = 9'(base + acc);
      @(negedge clk);
      if (rd_valid && rd_ready) acc++;
      if (resp_valid && resp_ready) begin
         got.push_back(resp_data);
         got_cyc.push_back(cyc);
      end
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_gnt[6];
      int misses;
      int stale;

      tbl[0] = '{9'd5,   32'hB000_0005, "rd5"};
      tbl[1] = '{9'd0,   32'hB000_0000, "rd0"};
      tbl[2] = '{9'd383, 32'hB000_017F, "rd383"};
      tbl[3] = '{9'd200, 32'hB000_00C8, "rd200"};
      tbl[4] = '{9'd500, 32'h0000_0000, "rd500_oor"};
      tbl[5] = '{9'd384, 32'h0000_0000, "rd384_oor"};

      // ---------------- reset state, with requests pending ----------------
      rst_n = 1'b0;
      wr_valid = 1'b1; rd_valid = 1'b1; resp_ready = 1'b1;
      wr_addr = 9'd3; rd_addr = 9'd4; wr_data = 32'h1234_5678;
      repeat (2) tick();
      @(negedge clk);
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_rd_ready", 32'(rd_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_oor_err", 32'(oor_err), 32'd0);
      check("rst_sram_cs", 32'(sram_cs), 32'd0);
      check("rst_sram_oe", 32'(sram_oe), 32'd0);
      check("rst_sram_web", 32'(sram_web), 32'd1);
      check("rst_sram_a", 32'(sram_a), 32'd0);
      check("rst_sram_di", sram_di, 32'd0);
      tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // ---------------- 1: load all words ----------------
      misses = 0;
      for (int a = 0; a < 384; a++) begin
         wr_valid = 1'b1;
         wr_addr  = 9'(a);
         wr_data  = 32'hB000_0000 + 32'(a);
         @(negedge clk);
         if (!wr_ready || !sram_cs || sram_web) misses++;
         tick();
      end
      wr_valid = 1'b0;
      check("load_grant_misses", 32'(misses), 32'd0);
      check("load_no_oor", 32'(oor_err), 32'd0);

      // ---------------- 5a: out-of-range write ----------------
      wr_valid = 1'b1; wr_addr = 9'd400; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("oor_wr_ready", 32'(wr_ready), 32'd1);
      check("oor_wr_cs", 32'(sram_cs), 32'd0);
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      check("oor_err_set", 32'(oor_err), 32'd1);
      tick();

      // ---------------- 1/5b: table of single reads ----------------
      for (int i = 0; i < 6; i++) do_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
      check("oor_err_sticky", 32'(oor_err), 32'd1);

      // ---------------- 2: streaming reads ----------------
      acc = 0; got.delete(); got_cyc.delete();
      resp_ready = 1'b1;
      for (int c = 0; c < 25; c++) stream_cycle(10, 10, c);
      rd_valid = 1'b0;
      check("stream_count", 32'(got.size()), 32'd10);
      if (got.size() > 0) check("stream_latency", 32'(got_cyc[0]), 32'd2);
      for (int i = 0; i < got.size() && i < 10; i++) begin
         check($sformatf("stream_data_%0d", i), got[i], 32'hB000_0000 + 32'(10 + i));
         check($sformatf("stream_cyc_%0d", i), 32'(got_cyc[i] - got_cyc[0]), 32'(i));
      end

      // ---------------- 3: backpressure ----------------
      acc = 0; got.delete(); got_cyc.delete();
      resp_ready = 1'b0;
      for (int c = 0; c < 8; c++) stream_cycle(20, 4, c);
      check("bp_accepted", 32'(acc), 32'd2);
      wr_valid = 1'b1; wr_addr = 9'd20; wr_data = 32'hB000_0014;
      @(negedge clk);
      check("bp_rd_stalled", 32'(rd_ready), 32'd0);
      check("bp_wr_granted", 32'(wr_ready), 32'd1);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_head", resp_data, 32'hB000_0014);
      tick();
      wr_valid = 1'b0;
      resp_ready = 1'b1;
      for (int c = 8; c < 30; c++) stream_cycle(20, 4, c);
      rd_valid = 1'b0;
      check("bp_total_accepted", 32'(acc), 32'd4);
      check("bp_resp_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size() && i < 4; i++)
         check($sformatf("bp_data_%0d", i), got[i], 32'hB000_0000 + 32'(20 + i));

      // ---------------- 4: conflict ----------------
      for (int i = 0; i < 6; i++) begin
`ifdef BIAS_SRAM_RR_EN
         exp_gnt[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
         exp_gnt[i] = 2'b10;
`endif
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      resp_ready = 1'b1;
      wr_valid = 1'b1; wr_addr = 9'd30; wr_data = 32'hB000_001E;
      rd_valid = 1'b1; rd_addr = 9'd31;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("conflict_%0d", i), 32'({wr_ready, rd_ready}), 32'(exp_gnt[i]));
         tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("conflict_drained", 32'(resp_valid), 32'd0);
      tick();

      // ---------------- 6: reset mid-read ----------------
      rd_valid = 1'b1; rd_addr = 9'd7;
      @(negedge clk);
      check("mid_rst_acc", 32'(rd_ready), 32'd1);
      tick();
      rd_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid) stale++;
         tick();
      end
      check("mid_rst_no_stale", 32'(stale), 32'd0);
      do_read(9'd7, 32'hB000_0007, "post_rst_rd7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
